data_mem_ctrl: RTL

- Data-memory window controller directly downstream of the address decoder; consumes its chip select, internal write enable and window-relative address.
- Serves one 32-bit load or store per request from a 1024-word RAM, with a programmable wait-state count and a one-cycle `ready` handshake back to the CPU stall logic.
- Flags out-of-range accesses and never corrupts memory on them.

---
 rtl/mem_pkg.sv | 19 +
 rtl/sp_ram.sv | 28 ++
 rtl/data_mem_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and state encoding for the data-memory window
package mem_pkg;

  // Default RAM geometry: 1024 words indexed by 10 bits
  localparam int MEM_DEPTH      = 1024;
  localparam int MEM_ADDR_WIDTH = 10;

  // Absolute bounds of the decoded data window, shared with the address decoder
  localparam logic [31:0] WIN_LO = 32'h0000_8F11;
  localparam logic [31:0] WIN_HI = 32'h0000_9310;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/sp_ram.sv
// rtl/sp_ram.sv - single-port synchronous RAM, registered read, no reset
module sp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter     INIT_FILE  = ""
) (
  input  logic                  CLK,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  // Write on enabled stores; dout only changes on enabled loads so it holds the last load
  always_ff @(posedge CLK) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= din;
      end else begin
        dout <= r_mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data-memory window controller with wait states and ready pulse
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int DEPTH       = MEM_DEPTH,
  parameter int WAIT_CYCLES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CS,
  input  logic                  iWE,
  input  logic [31:0]           iAddress,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  // The wait counter is 4 bits wide, so larger wait counts cannot be represented
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("data_mem_ctrl: WAIT_CYCLES must be in 0..15");
  end

  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [31:0] DEPTH_32  = 32'(DEPTH);

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_cnt;
  logic [31:0]           r_addr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;
  logic                  r_rd_zero;
  logic                  w_accept;
  logic                  w_op;
  logic                  w_in_range;
  logic                  w_ram_en;
  logic [DATA_WIDTH-1:0] w_dout;

  // The RAM operation happens on the last ACCESS edge; range is judged on all 32 bits
  assign w_accept   = (r_state == IDLE) && CS;
  assign w_op       = (r_state == ACCESS) && (r_cnt == 4'd0);
  assign w_in_range = (r_addr < DEPTH_32);
  assign w_ram_en   = w_op && w_in_range;

  // State register; reset abandons any captured request
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    w_next_state = r_state;
    ready        = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        if (CS) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (r_cnt == 4'd0) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        ready        = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Wait-state counter: loaded on acceptance, counts down while in ACCESS
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= WAIT_INIT;
    end else if ((r_state == ACCESS) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request capture; inputs are only looked at when a request is accepted
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr  <= 32'd0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_addr  <= iAddress;
      r_we    <= iWE;
      r_wdata <= wdata;
    end
  end

  // Completion status: err on every completion, rdata zero-mask on every load
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err     <= 1'b0;
      r_rd_zero <= 1'b1;
    end else if (w_op) begin
      r_err <= ~w_in_range;
      if (!r_we) begin
        r_rd_zero <= ~w_in_range;
      end
    end
  end

  // The RAM read register holds the last in-range load; the mask covers reset and bad loads
  assign rdata = r_rd_zero ? '0 : w_dout;
  assign err   = r_err;

  sp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .CLK  (CLK),
    .en   (w_ram_en),
    .we   (r_we),
    .addr (r_addr[ADDR_WIDTH-1:0]),
    .din  (r_wdata),
    .dout (w_dout)
  );

endmodule
